mem_responder: RTL and testbench

- Memory-side slave for the processor's data/instruction address bus; the responder end of the bus driven by the CPU memory control path.
- Accepts one request at a time (address, rw, write data) and serves it from an internal word array after a programmable number of wait states.
- Returns read data with a one-cycle ready pulse.
- Flags out-of-range accesses with err.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/mem_word_array.sv | 30 +++
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: rw encoding, responder states and default sizes.
// The CPU-side memory control imports the same package so rw polarity agrees.
package mem_bus_pkg;

  localparam int unsigned DEF_DEPTH = 256;
  localparam int unsigned DEF_AW    = 16;
  localparam int unsigned DEF_DW    = 32;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_word_array.sv
// Synchronous single-port DEPTH x DW word storage with a registered read port.
// Contents are deliberately not reset.
module mem_word_array
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] index,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write when enabled; always register the addressed word (read-before-write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[index] <= wdata;
    end
    rdata_q <= mem_q[index];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: accepts one request at a time, inserts
// WAIT_STATES wait cycles, then completes with a one-cycle ready pulse.
// Out-of-range addresses complete normally but raise err and touch nothing.
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          err,
  output logic          busy
);

  localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rw_q, rw_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          accept;
  logic          enter_resp;
  logic [AW-1:0] cur_addr;
  logic          cur_rw;
  logic [DW-1:0] cur_wdata;
  logic          cur_oor;
  logic          arr_we;
  logic [DW-1:0] arr_rdata;

  // State, wait counter, latched request fields and held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= RW_READ;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and wait-counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latching and completion datapath. With zero wait states the
  // array is accessed on the acceptance edge itself, so the live bus fields
  // are used while in IDLE and the latched copies afterwards.
  always_comb begin
    accept     = (state_q == IDLE) && req;
    addr_d     = accept ? addr  : addr_q;
    rw_d       = accept ? rw    : rw_q;
    wdata_d    = accept ? wdata : wdata_q;
    cur_addr   = (state_q == IDLE) ? addr  : addr_q;
    cur_rw     = (state_q == IDLE) ? rw    : rw_q;
    cur_wdata  = (state_q == IDLE) ? wdata : wdata_q;
    cur_oor    = ({1'b0, cur_addr} >= DEPTH_W);
    enter_resp = (state_d == RESP) && (state_q != RESP);
    arr_we     = enter_resp && (cur_rw == RW_WRITE) && !cur_oor;
    rdata_d    = rdata_q;
    if ((state_q == RESP) && (rw_q == RW_READ)) begin
      rdata_d = cur_oor ? '0 : arr_rdata;
    end
  end

  // Bus outputs; rdata shows the completing read during RESP and the held
  // value at all other times.
  always_comb begin
    ready = (state_q == RESP);
    err   = (state_q == RESP) && cur_oor;
    busy  = (state_q != IDLE);
    rdata = rdata_d;
  end

  mem_word_array #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .index (cur_addr[IW-1:0]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder with three instances at
// WAIT_STATES = 0, 1 and 3 sharing clock, reset and bus fields.
module tb_mem_responder;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, req3;
  logic        rw;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata1, rdata3;
  logic        ready0, ready1, ready3;
  logic        err0, err1, err3;
  logic        busy0, busy1, busy3;

  int errors = 0;
  int checks = 0;
  int sel    = 1;

  logic [31:0] rd_s;
  logic        rdy_s, err_s, busy_s;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(256), .AW(16), .DW(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0));
  mem_responder #(.DEPTH(256), .AW(16), .DW(32), .WAIT_STATES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1));
  mem_responder #(.DEPTH(256), .AW(16), .DW(32), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .ready(ready3), .err(err3), .busy(busy3));

  always_comb begin
    case (sel)
      0:       begin rd_s = rdata0; rdy_s = ready0; err_s = err0; busy_s = busy0; end
      3:       begin rd_s = rdata3; rdy_s = ready3; err_s = err3; busy_s = busy3; end
      default: begin rd_s = rdata1; rdy_s = ready1; err_s = err1; busy_s = busy1; end
    endcase
  end

  task automatic set_req(input logic v);
    case (sel)
      0:       req0 = v;
      3:       req3 = v;
      default: req1 = v;
    endcase
  endtask

  // One transaction on the selected instance; lat counts cycles after acceptance.
  task automatic txn(input logic r, input logic [15:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat,
                     output logic busy_ok, output logic width_ok);
    @(negedge clk);
    rw = r; addr = a; wdata = d; set_req(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0);
    lat = 1; busy_ok = 1'b1;
    while (!rdy_s && lat < 40) begin
      if (!busy_s) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy_s) busy_ok = 1'b0;
    rd = rd_s; e = err_s;
    @(negedge clk);
    width_ok = !rdy_s && !err_s && !busy_s;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic e, bok, wok; int lat;
    rst_n = 1'b0; req0 = 0; req1 = 0; req3 = 0; rw = RW_READ; addr = '0; wdata = '0;
    #1;
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err1); end
    checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b%b expected 00", busy1, busy3); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 00000000", rdata1); end
    #21 rst_n = 1'b1;
    sel = 1;
    txn(RW_WRITE, 16'd9, 32'h1122_3344, rd, e, lat, bok, wok);
    txn(RW_READ, 16'd9, 32'h0, rd, e, lat, bok, wok);
    checks++; if (rd !== 32'h1122_3344) begin errors++; $display("FAIL rst_pre_read: got %h expected 11223344", rd); end
    @(negedge clk);
    rw = RW_READ; addr = 16'd9; req1 = 1'b1;
    @(posedge clk);
    #2 req1 = 1'b0;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy1); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0 || ready1 !== 1'b0 || err1 !== 1'b0) begin
      errors++; $display("FAIL rst_async_ctl: got busy=%b ready=%b err=%b expected 0 0 0", busy1, ready1, err1); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_async_rdata: got %h expected 00000000", rdata1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e, bok, wok; int lat;
    sel = 1;
    txn(RW_WRITE, 16'd5, 32'h0000_002A, rd, e, lat, bok, wok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat: got %0d expected 2", lat); end
    checks++; if (e !== 1'b0 || wok !== 1'b1) begin errors++; $display("FAIL wr_err_width: got err=%b width_ok=%b expected 0 1", e, wok); end
    txn(RW_READ, 16'd5, 32'h0, rd, e, lat, bok, wok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_lat: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0000_002A) begin errors++; $display("FAIL rd_data: got %h expected 0000002a", rd); end
    checks++; if (e !== 1'b0 || wok !== 1'b1) begin errors++; $display("FAIL rd_err_width: got err=%b width_ok=%b expected 0 1", e, wok); end
    txn(RW_WRITE, 16'd6, 32'h0000_0099, rd, e, lat, bok, wok);
    checks++; if (rd !== 32'h0000_002A || rd_s !== 32'h0000_002A) begin
      errors++; $display("FAIL rdata_hold_on_write: got %h/%h expected 0000002a", rd, rd_s); end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic e, bok, wok; int lat;
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0) ? 0 : 3;
      txn(RW_WRITE, 16'd10, 32'hA5A5_0000 + 32'(sel), rd, e, lat, bok, wok);
      checks++; if (lat !== sel + 1) begin errors++; $display("FAIL lat_wr_ws%0d: got %0d expected %0d", sel, lat, sel + 1); end
      txn(RW_READ, 16'd10, 32'h0, rd, e, lat, bok, wok);
      checks++; if (lat !== sel + 1) begin errors++; $display("FAIL lat_rd_ws%0d: got %0d expected %0d", sel, lat, sel + 1); end
      checks++; if (rd !== 32'hA5A5_0000 + 32'(sel)) begin errors++; $display("FAIL lat_data_ws%0d: got %h expected %h", sel, rd, 32'hA5A5_0000 + 32'(sel)); end
      checks++; if (bok !== 1'b1 || wok !== 1'b1) begin errors++; $display("FAIL lat_busy_width_ws%0d: got busy_ok=%b width_ok=%b expected 1 1", sel, bok, wok); end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic e, bok, wok; int lat;
    sel = 1;
    txn(RW_WRITE, 16'd0, 32'h1234_5678, rd, e, lat, bok, wok);
    txn(RW_WRITE, 16'd255, 32'h0000_00FF, rd, e, lat, bok, wok);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL oor_edge255_err: got %b expected 0", e); end
    txn(RW_WRITE, 16'h0100, 32'hDEAD_BEEF, rd, e, lat, bok, wok);
    checks++; if (e !== 1'b1 || lat !== 2) begin errors++; $display("FAIL oor_wr: got err=%b lat=%0d expected 1 2", e, lat); end
    txn(RW_WRITE, 16'hFFFF, 32'h0000_CAFE, rd, e, lat, bok, wok);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_ffff: got %b expected 1", e); end
    txn(RW_READ, 16'd0, 32'h0, rd, e, lat, bok, wok);
    checks++; if (rd !== 32'h1234_5678 || e !== 1'b0) begin errors++; $display("FAIL oor_addr0_kept: got %h err=%b expected 12345678 0", rd, e); end
    txn(RW_READ, 16'd255, 32'h0, rd, e, lat, bok, wok);
    checks++; if (rd !== 32'h0000_00FF || e !== 1'b0) begin errors++; $display("FAIL oor_addr255_kept: got %h err=%b expected 000000ff 0", rd, e); end
    txn(RW_READ, 16'h0100, 32'h0, rd, e, lat, bok, wok);
    checks++; if (rd !== 32'h0 || e !== 1'b1 || lat !== 2) begin errors++; $display("FAIL oor_rd: got %h err=%b lat=%0d expected 00000000 1 2", rd, e, lat); end
    checks++; if (rd_s !== 32'h0 || wok !== 1'b1) begin errors++; $display("FAIL oor_rd_after: got %h width_ok=%b expected 00000000 1", rd_s, wok); end
  endtask

  task automatic test_req_during_wait();
    logic [31:0] rd, got; logic e, bok, wok; int lat, pulses, pulse_at;
    sel = 3;
    txn(RW_WRITE, 16'd3, 32'h0000_0033, rd, e, lat, bok, wok);
    txn(RW_WRITE, 16'd4, 32'h0000_0044, rd, e, lat, bok, wok);
    @(negedge clk);
    rw = RW_READ; addr = 16'd3; req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rw = RW_WRITE; addr = 16'd4; wdata = 32'h0000_0BAD;
    pulses = 0; pulse_at = -1; got = '0;
    for (int i = 0; i < 10; i++) begin
      if (rdy_s) begin pulses++; pulse_at = i; got = rd_s; end
      if (i == 2) req3 = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (pulses !== 1 || pulse_at !== 3) begin errors++; $display("FAIL busy_req_pulses: got %0d at %0d expected 1 at 3", pulses, pulse_at); end
    checks++; if (got !== 32'h0000_0033) begin errors++; $display("FAIL busy_req_data: got %h expected 00000033", got); end
    txn(RW_READ, 16'd4, 32'h0, rd, e, lat, bok, wok);
    checks++; if (rd !== 32'h0000_0044) begin errors++; $display("FAIL busy_req_addr4: got %h expected 00000044", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic e, bok, wok; int lat;
    sel = 3;
    txn(RW_WRITE, 16'd7, 32'h0000_0077, rd, e, lat, bok, wok);
    @(negedge clk);
    rw = RW_WRITE; addr = 16'd7; wdata = 32'h0000_0055; req3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req3 = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (busy3 !== 1'b0 || ready3 !== 1'b0) begin errors++; $display("FAIL midwait_rst: got busy=%b ready=%b expected 0 0", busy3, ready3); end
    @(negedge clk);
    rst_n = 1'b1;
    txn(RW_READ, 16'd7, 32'h0, rd, e, lat, bok, wok);
    checks++; if (rd !== 32'h0000_0077 || e !== 1'b0 || lat !== 4) begin
      errors++; $display("FAIL midwait_readback: got %h err=%b lat=%0d expected 00000077 0 4", rd, e, lat); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    sel = 0;
    pat = '0;
    @(negedge clk);
    rw = RW_READ; addr = 16'd10; req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      pat = {pat[4:0], rdy_s};
    end
    req0 = 1'b0;
    checks++; if (pat !== 6'b101010) begin errors++; $display("FAIL b2b_pattern: got %b expected 101010", pat); end
    checks++; if (rd_s !== 32'hA5A5_0000) begin errors++; $display("FAIL b2b_data: got %h expected a5a50000", rd_s); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_out_of_range();
    test_req_during_wait();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
